// File: rtl/nios2_oci_dct_packer_if.sv
// Atom-in / frame-out bundle for the OCI compressed-trace packer.
//   atom_valid, atom_data : trace atom from the CPU (no back-pressure)
//   out_valid, out_ready  : frame handshake toward the trace FIFO
//   out_data              : {count[3:0], buffer[29:0]}
// master = packer side, slave = source/FIFO side.
interface nios2_oci_dct_packer_if;
    logic        atom_valid;
    logic [1:0]  atom_data;
    logic        out_valid;
    logic        out_ready;
    logic [33:0] out_data;

    modport master (
        input  atom_valid,
        input  atom_data,
        input  out_ready,
        output out_valid,
        output out_data
    );

    modport slave (
        output atom_valid,
        output atom_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/nios2_oci_dct_packer.sv
// OCI compressed-trace (DCT) packer: packs 2-bit trace atoms LSB-first into a
// 30-bit buffer and emits {count, buffer} frames on full, flush, trace disable
// or idle timeout.
//   clk, reset_n        : clock, synchronous active-low reset
//   bus (master)        : atom input and frame valid/ready output
//   trace_enable        : atoms accepted only while high; falling edge flushes
//   flush               : one-cycle request to emit the partial buffer
//   dct_buffer/dct_count: live accumulation state
//   overflow, drop_count: sticky drop flag and saturating drop counter
//   overflow_clr        : clears overflow and drop_count
module nios2_oci_dct_packer #(
    parameter int unsigned ATOMS_PER_FRAME = 15,
    parameter int unsigned FLUSH_TIMEOUT   = 64
) (
    input  logic                          clk,
    input  logic                          reset_n,
    nios2_oci_dct_packer_if.master        bus,
    input  logic                          trace_enable,
    input  logic                          flush,
    input  logic                          overflow_clr,
    output logic [29:0]                   dct_buffer,
    output logic [3:0]                    dct_count,
    output logic                          overflow,
    output logic [7:0]                    drop_count
);

    localparam int unsigned IDLE_W = 10;
    localparam int unsigned BUF_W  = 30;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DROP_W = 8;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(ATOMS_PER_FRAME);
    localparam logic [IDLE_W-1:0] TMO_CNT  = IDLE_W'(FLUSH_TIMEOUT - 1);

    // Output frame slot: empty, or holding a frame awaiting out_ready.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    slot_state_e         state_q, state_d;
    logic [33:0]         out_data_q, out_data_d;
    logic [BUF_W-1:0]    buf_q, buf_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic                en_prev_q;
    logic                ovf_q, ovf_d;
    logic [DROP_W-1:0]   drop_q, drop_d;

    logic                slot_free;
    logic                cnt_full;
    logic                cnt_nz;
    logic                tmo;
    logic                commit;
    logic                atom_req;
    logic                accept;
    logic                drop;
    logic                en_fall;
    logic [CNT_W-1:0]    slot;

    // Cycle decisions shared by all next-state logic.
    assign slot_free = (state_q == SLOT_EMPTY) | bus.out_ready;
    assign cnt_full  = (cnt_q == FULL_CNT);
    assign cnt_nz    = (cnt_q != '0);
    assign tmo       = (idle_q == TMO_CNT);
    assign commit    = slot_free & cnt_nz & (cnt_full | pend_q | flush | tmo);
    assign atom_req  = bus.atom_valid & trace_enable;
    // Count never exceeds FULL_CNT, so "not full" is "below full".
    assign accept    = atom_req & (~cnt_full | commit);
    assign drop      = atom_req & cnt_full & ~commit;
    assign en_fall   = en_prev_q & ~trace_enable;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= SLOT_EMPTY;
            out_data_q <= '0;
            buf_q      <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            idle_q     <= '0;
            en_prev_q  <= 1'b0;
            ovf_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            idle_q     <= idle_d;
            en_prev_q  <= trace_enable;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        idle_d     = idle_q;
        ovf_d      = ovf_q;
        drop_d     = drop_q;
        slot       = cnt_q;

        // Frame slot: a commit refills it even while a handshake completes.
        if (commit) begin
            state_d    = SLOT_FULL;
            out_data_d = {cnt_q, buf_q};
        end else if ((state_q == SLOT_FULL) && bus.out_ready) begin
            state_d    = SLOT_EMPTY;
        end

        // Buffer: commit empties it; a same-cycle atom lands in slot 0.
        if (commit) begin
            buf_d = '0;
            cnt_d = '0;
            slot  = '0;
        end
        if (accept) begin
            buf_d[{slot, 1'b0} +: 2] = bus.atom_data;
            cnt_d                    = slot + CNT_W'(1);
        end

        // Deferred flush request, remembered until the slot frees up.
        if (commit) begin
            pend_d = 1'b0;
        end else if ((flush | en_fall) & cnt_nz) begin
            pend_d = 1'b1;
        end

        // Idle timer: only advances when a timeout could actually commit.
        if (commit | accept | ~cnt_nz) begin
            idle_d = '0;
        end else if (slot_free) begin
            idle_d = idle_q + IDLE_W'(1);
        end

        // Overflow tracking: a drop beats a same-cycle clear.
        if (drop) begin
            ovf_d  = 1'b1;
            if (overflow_clr) begin
                drop_d = DROP_W'(1);
            end else if (drop_q != {DROP_W{1'b1}}) begin
                drop_d = drop_q + DROP_W'(1);
            end
        end else if (overflow_clr) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end
    end

    assign bus.out_valid = (state_q == SLOT_FULL);
    assign bus.out_data  = out_data_q;
    assign dct_buffer    = buf_q;
    assign dct_count     = cnt_q;
    assign overflow      = ovf_q;
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Self-checking bench for nios2_oci_dct_packer: directed scenarios followed by
// a randomized phase, compared every cycle against a queue-based model.
module tb_nios2_oci_dct_packer;

    localparam int APF = 15;
    localparam int FT  = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        trace_enable = 1'b0;
    logic        flush = 1'b0;
    logic        overflow_clr = 1'b0;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;
    logic [7:0]  drop_count;

    int total = 0;
    int bad   = 0;

    nios2_oci_dct_packer_if bus();

    nios2_oci_dct_packer #(
        .ATOMS_PER_FRAME(APF),
        .FLUSH_TIMEOUT  (FT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .trace_enable(trace_enable),
        .flush       (flush),
        .overflow_clr(overflow_clr),
        .dct_buffer  (dct_buffer),
        .dct_count   (dct_count),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    // Reference model: the pending atoms are simply a queue.
    logic [1:0]  m_q[$];
    bit          m_valid = 0;
    logic [33:0] m_data  = '0;
    bit          m_pend  = 0;
    int          m_idle  = 0;
    bit          m_prev_en = 0;
    bit          m_ovf   = 0;
    int          m_drops = 0;

    function automatic logic [29:0] pack(input logic [1:0] q[$]);
        logic [29:0] r = '0;
        for (int i = 0; i < q.size(); i++) r[2*i +: 2] = q[i];
        return r;
    endfunction

    task automatic model_step();
        int n;
        bit full, sfree, tmo, commit, req, acc, drp, efall;
        if (!reset_n) begin
            m_q.delete();
            m_valid = 0; m_data = '0; m_pend = 0; m_idle = 0;
            m_prev_en = 0; m_ovf = 0; m_drops = 0;
            return;
        end
        n      = m_q.size();
        full   = (n == APF);
        sfree  = !m_valid || bus.out_ready;
        tmo    = (m_idle == FT - 1);
        commit = sfree && n != 0 && (full || m_pend || flush || tmo);
        req    = bus.atom_valid && trace_enable;
        acc    = req && (!full || commit);
        drp    = req && full && !commit;
        efall  = m_prev_en && !trace_enable;

        if (commit || acc || n == 0) m_idle = 0;
        else if (sfree)              m_idle++;

        if (commit)                          m_pend = 0;
        else if ((flush || efall) && n != 0) m_pend = 1;

        if (commit) begin
            m_data  = {4'(n), pack(m_q)};
            m_valid = 1;
            m_q.delete();
        end else if (m_valid && bus.out_ready) begin
            m_valid = 0;
        end
        if (acc) m_q.push_back(bus.atom_data);

        if (drp) begin
            m_ovf   = 1;
            m_drops = overflow_clr ? 1 : (m_drops == 255 ? 255 : m_drops + 1);
        end else if (overflow_clr) begin
            m_ovf   = 0;
            m_drops = 0;
        end
        m_prev_en = trace_enable;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out_valid",  64'(bus.out_valid), 64'(m_valid));
        chk("out_data",   64'(bus.out_data),  64'(m_data));
        chk("dct_count",  64'(dct_count),     64'(m_q.size()));
        chk("dct_buffer", 64'(dct_buffer),    64'(pack(m_q)));
        chk("overflow",   64'(overflow),      64'(m_ovf));
        chk("drop_count", 64'(drop_count),    64'(m_drops));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic atom(input logic [1:0] d);
        bus.atom_valid = 1'b1;
        bus.atom_data  = d;
        cycle();
        bus.atom_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 64'(bus.out_valid), 0);
        chk({tag, "_data"},  64'(bus.out_data),  0);
        chk({tag, "_buf"},   64'(dct_buffer),    0);
        chk({tag, "_cnt"},   64'(dct_count),     0);
        chk({tag, "_ovf"},   64'(overflow),      0);
        chk({tag, "_drop"},  64'(drop_count),    0);
    endtask

    task automatic scen_full();
        bus.out_ready = 1'b1;
        trace_enable  = 1'b1;
        for (int i = 0; i < 15; i++) atom(2'b01);
        chk("s1_count15", 64'(dct_count), 15);
        cycle();
        chk("s1_valid", 64'(bus.out_valid), 1);
        chk("s1_data",  64'(bus.out_data),  64'({4'hF, 30'h15555555}));
        chk("s1_cnt0",  64'(dct_count),     0);
        chk("s1_ovf",   64'(overflow),      0);
        cycle();
        chk("s1_drain", 64'(bus.out_valid), 0);
    endtask

    initial begin
        bus.atom_valid = 1'b0;
        bus.atom_data  = 2'b00;
        bus.out_ready  = 1'b0;

        // Reset
        reset_n = 1'b0;
        cycle();
        cycle();
        check_zero("reset");
        reset_n = 1'b1;

        // 1: full frame of 2'b01
        scen_full();

        // 2: partial frame on flush, then flush with empty buffer
        atom(2'b11);
        atom(2'b10);
        atom(2'b01);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("s2_valid", 64'(bus.out_valid), 1);
        chk("s2_data",  64'(bus.out_data),  64'({4'h3, 30'h0000001B}));
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("s2_empty_flush", 64'(bus.out_valid), 0);
        cycle();
        chk("s2_no_frame", 64'(bus.out_valid), 0);

        // 3: back-pressure, overflow, drop saturation, clear
        bus.out_ready = 1'b0;
        for (int i = 0; i < 15; i++) atom(2'b10);
        for (int i = 0; i < 15; i++) atom(2'b11);
        atom(2'b00);
        atom(2'b00);
        chk("s3_ovf",   64'(overflow),      1);
        chk("s3_drop",  64'(drop_count),    2);
        chk("s3_cnt",   64'(dct_count),     15);
        chk("s3_data1", 64'(bus.out_data),  64'({4'hF, 30'h2AAAAAAA}));
        for (int i = 0; i < 300; i++) atom(2'b01);
        chk("s3_sat", 64'(drop_count), 255);
        bus.atom_valid = 1'b1;
        overflow_clr   = 1'b1;
        cycle();
        bus.atom_valid = 1'b0;
        overflow_clr   = 1'b0;
        chk("s3_clr_drop_wins", 64'(drop_count), 1);
        overflow_clr = 1'b1;
        cycle();
        overflow_clr = 1'b0;
        chk("s3_clr_ovf",  64'(overflow),   0);
        chk("s3_clr_drop", 64'(drop_count), 0);
        bus.out_ready = 1'b1;
        cycle();
        chk("s3_valid2", 64'(bus.out_valid), 1);
        chk("s3_data2",  64'(bus.out_data),  64'({4'hF, 30'h3FFFFFFF}));
        chk("s3_cnt0",   64'(dct_count),     0);
        cycle();
        chk("s3_drain", 64'(bus.out_valid), 0);

        // 4: idle timeout, then restart by a late atom
        for (int i = 0; i < 5; i++) atom(2'b10);
        idle(FT - 1);
        chk("s4_not_yet", 64'(bus.out_valid), 0);
        cycle();
        chk("s4_tmo",     64'(bus.out_valid),       1);
        chk("s4_tmo_cnt", 64'(bus.out_data[33:30]), 5);
        cycle();
        for (int i = 0; i < 5; i++) atom(2'b01);
        idle(FT - 2);
        atom(2'b11);
        idle(FT - 1);
        chk("s4_restart_hold", 64'(bus.out_valid), 0);
        cycle();
        chk("s4_restart_tmo", 64'(bus.out_valid),       1);
        chk("s4_restart_cnt", 64'(bus.out_data[33:30]), 6);
        cycle();

        // 5: trace disable flushes; disabled atoms ignored
        for (int i = 0; i < 4; i++) atom(2'b11);
        trace_enable   = 1'b0;
        bus.atom_valid = 1'b1;
        cycle();
        chk("s5_pend", 64'(bus.out_valid), 0);
        cycle();
        chk("s5_valid", 64'(bus.out_valid),       1);
        chk("s5_cnt",   64'(bus.out_data[33:30]), 4);
        cycle();
        chk("s5_cnt0", 64'(dct_count), 0);
        chk("s5_ovf",  64'(overflow),  0);
        bus.atom_valid = 1'b0;
        trace_enable   = 1'b1;
        cycle();

        // 6: reset mid-handshake discards the frame
        bus.out_ready = 1'b0;
        for (int i = 0; i < 15; i++) atom(2'b01);
        cycle();
        chk("s6_stalled", 64'(bus.out_valid), 1);
        reset_n = 1'b0;
        cycle();
        check_zero("s6_reset");
        reset_n = 1'b1;
        trace_enable = 1'b0;
        cycle();
        scen_full();

        // Randomized phase
        for (int i = 0; i < 2500; i++) begin
            reset_n        = ($urandom_range(0, 299) != 0);
            trace_enable   = ($urandom_range(0, 19) != 0);
            bus.atom_valid = ($urandom_range(0, 3) != 0);
            bus.atom_data  = 2'($urandom);
            flush          = ($urandom_range(0, 15) == 0);
            bus.out_ready  = ($urandom_range(0, 2) != 0);
            overflow_clr   = ($urandom_range(0, 40) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nios2_oci_dct_packer.md
Name: nios2_oci_dct_packer

Overview:
Trace-side controller for the OCI compressed-trace (DCT) path. It accumulates 2-bit trace atoms into a 30-bit DCT buffer and tracks the fill level in a 4-bit DCT count. It schedules emission of frames to the downstream trace FIFO on full, explicit flush, trace disable or idle timeout. It sits between the CPU trace-atom source, which can never be stalled, and the on-chip trace memory write port, which uses valid/ready.

Parameters:
ATOMS_PER_FRAME, 15, atoms per full frame; legal 1..15 (30-bit buffer, 2 bits per atom).
FLUSH_TIMEOUT, 64, idle cycles with a partial buffer before auto-flush; legal 2..1023.

Ports:
clk  in  1  single clock; all logic on rising edge
reset_n  in  1  synchronous, active-low reset
trace_enable  in  1  atoms accepted only while high
atom_valid  in  1  atom present this cycle; no ready (source cannot stall)
atom_data  in  2  trace atom
flush  in  1  single-cycle request to emit partial buffer
out_valid  out  1  frame available to trace FIFO
out_ready  in  1  trace FIFO accepts frame
out_data  out  34  {count[3:0], buffer[29:0]}
dct_buffer  out  30  live accumulation buffer
dct_count  out  4  live atom count, 0..ATOMS_PER_FRAME
overflow  out  1  sticky; an atom was dropped
overflow_clr  in  1  clears overflow
drop_count  out  8  saturating count of dropped atoms; cleared by overflow_clr

Behaviour:
- Reset (reset_n low at clk edge): every output is 0 and flush_pend, idle counter and previous trace_enable are 0. This overrides all other activity, including a frame mid-handshake; the pending frame is discarded.
- Atom accept: accept = atom_valid & trace_enable & (dct_count < ATOMS_PER_FRAME | commit). An accepted atom is written at bits [2k+1:2k], where k is its slot; slot = 0 if commit this cycle, else dct_count. LSB first.
- Drop: atom_valid & trace_enable & dct_count == ATOMS_PER_FRAME & ~commit. The atom is discarded, overflow is set to 1 and drop_count increments, saturating at 255.
- slot_free = ~out_valid | out_ready.
- Commit condition: commit = slot_free & dct_count != 0 & (dct_count == ATOMS_PER_FRAME | flush_pend | flush | tmo).
- On commit:
  - out_data <= {dct_count, dct_buffer}; out_valid <= 1.
  - dct_buffer is cleared; any atom accepted in the same cycle lands in slot 0, giving dct_count = 1.
  - flush_pend is cleared and the idle counter is cleared.
- Output handshake: out_valid & out_ready with no commit in the same cycle gives out_valid <= 0. out_data is held stable while out_valid & ~out_ready.
- flush_pend:
  - Set by flush, or by a trace_enable falling edge (registered previous value 1, current 0), when dct_count != 0 and no commit occurs this cycle.
  - Cleared on commit.
  - A flush while dct_count == 0 has no effect.
- Idle timeout: the idle counter increments each cycle with dct_count != 0 and no accept; it resets to 0 on accept or commit. tmo = (idle == FLUSH_TIMEOUT-1). The counter holds while blocked by ~slot_free.
- Overflow: overflow_clr clears overflow and drop_count. A drop in the same cycle wins: overflow = 1, drop_count = 1.
- Latency:
  - The ATOMS_PER_FRAME-th atom accepted at edge t gives commit at t+1 and out_valid high after t+1, provided the slot is free.
  - A flush sampled at edge t with slot free gives out_valid high after edge t.
- Full-frame count: out_data[33:30] = 4'hF for ATOMS_PER_FRAME = 15.
- Priority within a cycle: reset > commit > accept/drop > flush_pend set > idle count.

Test Plan:
1. Reset, enable; 15 atoms 2'b01 back-to-back with out_ready=1 -> out_valid 1 cycle after count hits 15; out_data = {4'hF, 30'h15555555}; dct_count returns to 0; overflow = 0.
2. 3 atoms 2'b11,2'b10,2'b01 then flush pulse -> out_data = {4'h3, 30'h0000001B}; flush with dct_count = 0 -> no frame.
3. out_ready = 0; 15 atoms fill the first frame; 15 more fill the buffer; 2 further atoms -> both dropped, overflow = 1, drop_count = 2; raise out_ready -> second frame 4'hF emitted one cycle after first accept.
4. 5 atoms then idle with FLUSH_TIMEOUT = 64 -> frame {4'h5, ...} committed exactly 64 cycles after last accept; an atom arriving at cycle 63 restarts the count instead.
5. 4 atoms, drop trace_enable -> frame count 4 emitted; atoms presented while disabled are ignored and do not set overflow.
6. Assert reset_n = 0 while out_valid = 1 & out_ready = 0 -> next cycle all outputs 0; then scenario 1 passes unchanged.
